// File: rtl/soc1_cpu_mul_pipe.sv
// soc1_cpu_mul_pipe
// Pipelined DATA_W x DATA_W integer multiplier for the soc1 CPU. The full
// 2*DATA_W product is built from four (H+1)x(H+1) partial products, where
// H = DATA_W/2, so that signed and unsigned operands share one datapath.
// hi_sel picks the upper or lower product word; in_valid and all sideband
// controls travel with their operands.
//
// PIPE_STAGES (1..3) sets the latency in enabled cycles:
//   1 : final sum register only
//   2 : partial-product register + final sum register
//   3 : as 2, plus an output register
//
// Optional feature macro: MUL_PIPE_ACCUM_EN
//   When defined, a 2*DATA_W accumulator sits in the final sum stage and is
//   controlled per operation by acc_en / acc_clr. When undefined, those inputs
//   are ignored and no accumulator is built.
module soc1_cpu_mul_pipe #(
    parameter int DATA_W      = 32,
    parameter int PIPE_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] src1,
    input  logic [DATA_W-1:0] src2,
    input  logic              src1_signed,
    input  logic              src2_signed,
    input  logic              hi_sel,
    input  logic              acc_en,
    input  logic              acc_clr,
    output logic              out_valid,
    output logic [DATA_W-1:0] result
);

    localparam int H  = DATA_W / 2;
    localparam int PW = DATA_W + 2;   // width of one (H+1)x(H+1) partial product
    localparam int FW = 2 * DATA_W;   // full product width

    generate
        if ((DATA_W % 2) != 0 || DATA_W < 8 || DATA_W > 64) begin : g_bad_width
            $fatal(1, "soc1_cpu_mul_pipe: DATA_W must be even and within 8..64");
        end
        if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
            $fatal(1, "soc1_cpu_mul_pipe: PIPE_STAGES must be within 1..3");
        end
    endgenerate

    // Signed (H+1)x(H+1) multiply done as an unsigned multiply of the
    // sign-extended operands; the low PW bits are the exact signed product.
    function automatic logic [PW-1:0] half_mul(input logic [H:0] x, input logic [H:0] y);
        logic [PW-1:0] xe;
        logic [PW-1:0] ye;
        xe = {{(PW-H-1){x[H]}}, x};
        ye = {{(PW-H-1){y[H]}}, y};
        return xe * ye;
    endfunction

    function automatic logic [FW-1:0] sext(input logic [PW-1:0] p);
        return {{(FW-PW){p[PW-1]}}, p};
    endfunction

    // Operand halves: low halves are always unsigned, high halves carry the
    // operand's signedness through an extra top bit.
    logic [H:0] a_lo, a_hi, b_lo, b_hi;

    assign a_lo = {1'b0, src1[H-1:0]};
    assign a_hi = {src1_signed & src1[DATA_W-1], src1[DATA_W-1:H]};
    assign b_lo = {1'b0, src2[H-1:0]};
    assign b_hi = {src2_signed & src2[DATA_W-1], src2[DATA_W-1:H]};

    logic [PW-1:0] pp_ll, pp_lh, pp_hl, pp_hh;

    assign pp_ll = half_mul(a_lo, b_lo);
    assign pp_lh = half_mul(a_lo, b_hi);
    assign pp_hl = half_mul(a_hi, b_lo);
    assign pp_hh = half_mul(a_hi, b_hi);

    // Partial products and sideband as seen by the final sum stage.
    logic [PW-1:0] q_ll, q_lh, q_hl, q_hh;
    logic          q_valid, q_hi_sel, q_acc_en, q_acc_clr;

    generate
        if (PIPE_STAGES >= 2) begin : g_pp_reg
            // Partial-product register with its sideband.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    q_ll      <= '0;
                    q_lh      <= '0;
                    q_hl      <= '0;
                    q_hh      <= '0;
                    q_valid   <= 1'b0;
                    q_hi_sel  <= 1'b0;
                    q_acc_en  <= 1'b0;
                    q_acc_clr <= 1'b0;
                end else if (en) begin
                    q_ll      <= pp_ll;
                    q_lh      <= pp_lh;
                    q_hl      <= pp_hl;
                    q_hh      <= pp_hh;
                    q_valid   <= in_valid;
                    q_hi_sel  <= hi_sel;
                    q_acc_en  <= acc_en;
                    q_acc_clr <= acc_clr;
                end
            end
        end else begin : g_pp_pass
            assign q_ll      = pp_ll;
            assign q_lh      = pp_lh;
            assign q_hl      = pp_hl;
            assign q_hh      = pp_hh;
            assign q_valid   = in_valid;
            assign q_hi_sel  = hi_sel;
            assign q_acc_en  = acc_en;
            assign q_acc_clr = acc_clr;
        end
    endgenerate

    // Weighted sum of the four partial products, exact modulo 2^FW.
    logic [FW-1:0] prod_sum;

    assign prod_sum = sext(q_ll)
                    + (sext(q_lh) << H)
                    + (sext(q_hl) << H)
                    + (sext(q_hh) << DATA_W);

    // Value whose selected word is returned by the current op.
    logic [FW-1:0] final_val;

`ifdef MUL_PIPE_ACCUM_EN
    logic [FW-1:0] acc_q;

    // Accumulator next value: clear wins over accumulate; plain ops pass P.
    always_comb begin
        final_val = prod_sum;
        if (q_valid && q_acc_clr) begin
            final_val = prod_sum;
        end else if (q_valid && q_acc_en) begin
            final_val = acc_q + prod_sum;
        end
    end

    // Accumulator register; bubbles and stalls never touch it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (en && q_valid && (q_acc_clr || q_acc_en)) begin
            acc_q <= final_val;
        end
    end
`else
    logic unused_acc_ctrl;

    assign final_val       = prod_sum;
    assign unused_acc_ctrl = q_acc_en ^ q_acc_clr;
`endif

    // Final sum register: selects the requested word of the result.
    logic              s_valid;
    logic [DATA_W-1:0] s_word;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s_valid <= 1'b0;
            s_word  <= '0;
        end else if (en) begin
            s_valid <= q_valid;
            s_word  <= q_hi_sel ? final_val[FW-1:DATA_W] : final_val[DATA_W-1:0];
        end
    end

    generate
        if (PIPE_STAGES == 3) begin : g_out_reg
            // Extra output register for timing relief toward the consumer.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_valid <= 1'b0;
                    result    <= '0;
                end else if (en) begin
                    out_valid <= s_valid;
                    result    <= s_word;
                end
            end
        end else begin : g_out_pass
            assign out_valid = s_valid;
            assign result    = s_word;
        end
    endgenerate

endmodule
